// File: rtl/pc_branch_unit.sv
// Next-PC / fetch-control unit: owns the PC and the IF/ID PC register, resolves
// B/CBZ/CBNZ from EX and redirects fetch with a one-cycle IF/ID bubble.
module pc_branch_unit #(
    parameter int unsigned           ADDR_W   = 64,
    parameter int unsigned           OFF_W    = 26,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0,
    parameter int unsigned           CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall_i,
    input  logic              br_valid_i,
    input  logic [1:0]        br_type_i,
    input  logic [ADDR_W-1:0] br_pc_i,
    input  logic [OFF_W-1:0]  br_offset_i,
    input  logic              br_zero_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [ADDR_W-1:0] ifid_pc_o,
    output logic [ADDR_W-1:0] ifid_pc4_o,
    output logic              ifid_valid_o,
    output logic              flush_o,
    output logic [CNT_W-1:0]  taken_cnt_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        REDIR = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              taken;
    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] target;

    assign off_ext = {{(ADDR_W-OFF_W){br_offset_i[OFF_W-1]}}, br_offset_i};
    assign target  = br_pc_i + {off_ext[ADDR_W-3:0], 2'b00};

    assign taken = br_valid_i & ((br_type_i == 2'b01) |
                                 ((br_type_i == 2'b10) &  br_zero_i) |
                                 ((br_type_i == 2'b11) & ~br_zero_i));

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        cnt_d        = cnt_q;
        if (taken) begin
            // the branch in EX is older than anything stalled behind it, so it wins
            pc_d         = target;
            ifid_valid_d = 1'b0;
            state_d      = REDIR;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (stall_i) begin
            state_d = (state_q == REDIR) ? REDIR : HOLD;
        end else begin
            pc_d         = pc_q + ADDR_W'(4);
            ifid_pc_d    = pc_q;
            ifid_valid_d = 1'b1;
            state_d      = RUN;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign imem_addr_o  = pc_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_pc4_o   = ifid_pc_q + ADDR_W'(4);
    assign ifid_valid_o = ifid_valid_q;
    assign flush_o      = taken & reset_n;
    assign taken_cnt_o  = cnt_q;

endmodule
